mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_MEM_BURST, default 4, meaning the maximum number of consecutive MEM grants while FE is waiting.
REQ-002 SHALL have the following ports, each given as name, direction, width, meaning:
- CLK  in  1  single clock; all logic rising-edge.
- RESET  in  1  synchronous, active-high reset.
- FE_REQ  in  1  fetch read request; held until FE_RVALID.
- FE_ADDR  in  64  fetch address; stable while FE_REQ is high.
- FE_FLUSH  in  1  branch redirect; squashes the fetch in flight.
- FE_RDATA  out  32  instruction word.
- FE_RVALID  out  1  one-cycle pulse; FE_RDATA valid.
- FE_STALL  out  1  fetch must hold.
- MEM_REQ  in  1  load/store request; held until MEM_RVALID.
- MEM_WE  in  1  1 = store.
- MEM_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- MEM_ADDR  in  64  data address.
- MEM_WDATA  in  64  store data.
- MEM_RDATA  out  64  load data.
- MEM_RVALID  out  1  one-cycle completion pulse for loads and stores.
- MEM_STALL  out  1  memory stage must hold.
- P_REQ  out  1  shared-port request; held until P_ACK.
- P_WE  out  1  shared-port write enable.
- P_SIZE  out  2  shared-port access size.
- P_ADDR  out  64  shared-port address.
- P_WDATA  out  64  shared-port write data.
- P_ACK  in  1  shared-port completion; may arrive 1 or more cycles after P_REQ rises.
- P_RDATA  in  64  shared-port read data; valid when P_ACK is high.

Function
REQ-003 SHALL implement FSM states IDLE, FE_WAIT and MEM_WAIT.
REQ-004 SHALL grant only from IDLE; a grant at edge t enters *_WAIT and asserts P_REQ from cycle t+1.
REQ-005 SHALL latch address, WE, size and wdata into registers at grant; P_* outputs come only from these registers and are stable while P_REQ is high.
REQ-006 SHALL give FE transactions P_WE=0 and P_SIZE=2.
REQ-007 SHALL resolve simultaneous requests in favour of MEM, unless streak==MAX_MEM_BURST, in which case FE wins.
REQ-008 SHALL maintain the streak counter as follows:
- +1 on a MEM grant while FE_REQ is high.
- Cleared on an FE grant, or when FE_REQ is low in IDLE.
- Saturates at MAX_MEM_BURST.
REQ-009 SHALL, on P_ACK in *_WAIT at cycle t, set the matching RVALID high for cycle t+1 only, drop P_REQ at t+1, and return to IDLE at t+1; the earliest re-grant is at edge t+1, with P_REQ at t+2.
REQ-010 SHALL register FE_RDATA = P_RDATA[31:0] when latched addr[2]=0, else P_RDATA[63:32].
REQ-011 SHALL register MEM_RDATA = P_RDATA for loads and 0 for stores; the block performs no sign or zero extension.
REQ-012 SHALL drive FE_STALL = FE_REQ & ~FE_RVALID and MEM_STALL = MEM_REQ & ~MEM_RVALID, combinationally.
REQ-013 SHALL not grant FE in IDLE while FE_FLUSH is high; MEM may still be granted that cycle.
REQ-014 SHALL, on FE_FLUSH in FE_WAIT, set the squash flag; the next P_ACK completes the transaction with FE_RVALID held at 0, returns to IDLE, and clears squash.
REQ-015 SHALL ignore P_ACK in IDLE.
REQ-016 SHALL not check address alignment; P_ADDR is passed unmodified.

Reset
REQ-017 SHALL, on RESET high at an edge, set state=IDLE, streak=0, squash=0, and P_REQ, P_WE, FE_RVALID and MEM_RVALID to 0; all data outputs go to 0.
REQ-018 SHALL abandon any in-flight transaction on reset mid-transaction, and SHALL ignore a late P_ACK per REQ-015.
REQ-019 SHALL give RESET priority over P_ACK and over FE_FLUSH in the same cycle.

Structure
REQ-020 SHALL take the FSM state enum, the MEM_SIZE encodings and the XLEN=64/ILEN=32 constants from the shared core package.
REQ-021 SHALL implement the streak counter and the grant decision in sub-module arb_fairness_ctr.

Verification
REQ-022 SHALL cover these directed scenarios:
- Lone FE_REQ at addr 0x1004, P_ACK 1 cycle after P_REQ with P_RDATA=0xAAAAAAAA_BBBBBBBB -> FE_RDATA=0xAAAAAAAA, FE_RVALID pulse at request+3.
- FE_REQ and MEM_REQ continuously high (MEM load addr 0x2000), P_ACK immediate -> grant order M,M,M,M,F,M,M,M,M,F.
- MEM store, addr 0x3000, size 3, wdata 0x1122334455667788 -> P_WE=1, P_WDATA matches, MEM_RVALID pulse with MEM_RDATA=0.
- FE_FLUSH in FE_WAIT, P_ACK 3 cycles later -> no FE_RVALID; next FE_REQ (new addr 0x4000) granted, returns data.
- RESET asserted in MEM_WAIT, P_ACK 1 cycle after reset -> P_REQ low after the edge, no MEM_RVALID, state IDLE.
- P_ACK held off 10 cycles -> P_ADDR/P_REQ stable throughout, FE_STALL/MEM_STALL high until RVALID.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared core definitions for the fetch/memory shared-port arbiter.
package mem_port_arbiter_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // Arbiter FSM: grants are only issued from IDLE.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FE_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } arb_state_e;

    // MEM_SIZE / P_SIZE encodings.
    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } mem_size_e;

    // Pick the 32-bit instruction word out of a 64-bit beat using address bit 2.
    function automatic logic [ILEN-1:0] select_word(input logic [XLEN-1:0] dword,
                                                    input logic            upper);
        return upper ? dword[XLEN-1:ILEN] : dword[ILEN-1:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: master = arbiter side, slave = memory side.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic            p_req;
    logic            p_we;
    logic [1:0]      p_size;
    logic [XLEN-1:0] p_addr;
    logic [XLEN-1:0] p_wdata;
    logic            p_ack;
    logic [XLEN-1:0] p_rdata;

    modport master (
        output p_req, p_we, p_size, p_addr, p_wdata,
        input  p_ack, p_rdata
    );

    modport slave (
        input  p_req, p_we, p_size, p_addr, p_wdata,
        output p_ack, p_rdata
    );

endinterface

// File: rtl/arb_fairness_ctr.sv
// Grant decision and MEM-streak counter that keeps fetch from starving.
module arb_fairness_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_MEM_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  arb_state_e state,
    input  logic       fe_req,
    input  logic       fe_flush,
    input  logic       mem_req,
    output logic       grant_fe,
    output logic       grant_mem
);

    localparam int                  STREAK_W   = $clog2(MAX_MEM_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_BURST);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                fe_ok;
    logic                fe_due;

    // Grant from IDLE only: MEM wins ties unless the streak has hit its cap.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_fe  = 1'b0;
        grant_mem = 1'b0;
        fe_ok     = fe_req & ~fe_flush;
        fe_due    = fe_ok && (streak_q == STREAK_MAX);
        if (state == IDLE) begin
            if (mem_req && !fe_due) begin
                grant_mem = 1'b1;
            end else if (fe_ok) begin
                grant_fe = 1'b1;
            end
        end
    end

    // Count MEM grants that overtook a waiting fetch; saturate at the cap.
    always_comb begin
        streak_d = streak_q;
        if (state == IDLE) begin
            if (grant_mem && fe_req) begin
                if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
            end else if (grant_fe || !fe_req) begin
                streak_d = '0;
            end
        end
    end

    // Streak register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so all flops update together from pre-edge values.
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and memory stages onto one shared memory port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_MEM_BURST = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FE_REQ,
    input  logic [XLEN-1:0] FE_ADDR,
    input  logic            FE_FLUSH,
    output logic [ILEN-1:0] FE_RDATA,
    output logic            FE_RVALID,
    output logic            FE_STALL,
    input  logic            MEM_REQ,
    input  logic            MEM_WE,
    input  logic [1:0]      MEM_SIZE,
    input  logic [XLEN-1:0] MEM_ADDR,
    input  logic [XLEN-1:0] MEM_WDATA,
    output logic [XLEN-1:0] MEM_RDATA,
    output logic            MEM_RVALID,
    output logic            MEM_STALL,
    output logic            P_REQ,
    output logic            P_WE,
    output logic [1:0]      P_SIZE,
    output logic [XLEN-1:0] P_ADDR,
    output logic [XLEN-1:0] P_WDATA,
    input  logic            P_ACK,
    input  logic [XLEN-1:0] P_RDATA
);

    arb_state_e      state_q, state_d;
    logic            grant_fe, grant_mem;
    logic            p_req_q, p_req_d;
    logic            we_q, we_d;
    mem_size_e       size_q, size_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            squash_q, squash_d;
    logic            fe_rvalid_q, fe_rvalid_d;
    logic            mem_rvalid_q, mem_rvalid_d;
    logic [ILEN-1:0] fe_rdata_q, fe_rdata_d;
    logic [XLEN-1:0] mem_rdata_q, mem_rdata_d;

    arb_fairness_ctr #(
        .MAX_MEM_BURST(MAX_MEM_BURST)
    ) u_fairness (
        .clk      (CLK),
        .reset    (RESET),
        .state    (state_q),
        .fe_req   (FE_REQ),
        .fe_flush (FE_FLUSH),
        .mem_req  (MEM_REQ),
        .grant_fe (grant_fe),
        .grant_mem(grant_mem)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant out of IDLE, return to IDLE on the port acknowledge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    state_d = MEM_WAIT;
                end else if (grant_fe) begin
                    state_d = FE_WAIT;
                end
            end
            FE_WAIT, MEM_WAIT: begin
                if (P_ACK) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: latch the request at grant, capture read data and pulse RVALID on ack.
    always_comb begin
        p_req_d      = p_req_q;
        we_d         = we_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        squash_d     = squash_q;
        fe_rvalid_d  = 1'b0;
        mem_rvalid_d = 1'b0;
        fe_rdata_d   = fe_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        unique case (state_q)
            IDLE: begin
                p_req_d  = 1'b0;
                squash_d = 1'b0;
                if (grant_mem) begin
                    p_req_d = 1'b1;
                    we_d    = MEM_WE;
                    size_d  = mem_size_e'(MEM_SIZE);
                    addr_d  = MEM_ADDR;
                    wdata_d = MEM_WDATA;
                end else if (grant_fe) begin
                    p_req_d = 1'b1;
                    we_d    = 1'b0;
                    size_d  = SIZE_WORD;
                    addr_d  = FE_ADDR;
                    wdata_d = '0;
                end
            end
            FE_WAIT: begin
                if (P_ACK) begin
                    p_req_d  = 1'b0;
                    squash_d = 1'b0;
                    // A redirect in the ack cycle squashes just like an earlier one.
                    if (!squash_q && !FE_FLUSH) begin
                        fe_rvalid_d = 1'b1;
                        fe_rdata_d  = select_word(P_RDATA, addr_q[2]);
                    end
                end else if (FE_FLUSH) begin
                    squash_d = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (P_ACK) begin
                    p_req_d      = 1'b0;
                    mem_rvalid_d = 1'b1;
                    mem_rdata_d  = we_q ? '0 : P_RDATA;
                end
            end
            default: p_req_d = 1'b0;
        endcase
    end

    // Output and request registers; everything clears on reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            p_req_q      <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= SIZE_BYTE;
            addr_q       <= '0;
            wdata_q      <= '0;
            squash_q     <= 1'b0;
            fe_rvalid_q  <= 1'b0;
            mem_rvalid_q <= 1'b0;
            fe_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            p_req_q      <= p_req_d;
            we_q         <= we_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            squash_q     <= squash_d;
            fe_rvalid_q  <= fe_rvalid_d;
            mem_rvalid_q <= mem_rvalid_d;
            fe_rdata_q   <= fe_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign P_REQ      = p_req_q;
    assign P_WE       = we_q;
    assign P_SIZE     = size_q;
    assign P_ADDR     = addr_q;
    assign P_WDATA    = wdata_q;
    assign FE_RVALID  = fe_rvalid_q;
    assign FE_RDATA   = fe_rdata_q;
    assign MEM_RVALID = mem_rvalid_q;
    assign MEM_RDATA  = mem_rdata_q;
    assign FE_STALL   = FE_REQ & ~fe_rvalid_q;
    assign MEM_STALL  = MEM_REQ & ~mem_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus, queued expectations, monitor compares.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [63:0] wdata;
    } grant_t;

    typedef struct {
        logic [63:0] data;
        int          cyc;   // -1 = arrival cycle not checked
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fe_req, fe_flush, mem_req, mem_we;
    logic [63:0] fe_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] fe_rdata;
    logic [63:0] mem_rdata;
    logic        fe_rvalid, fe_stall, mem_rvalid, mem_stall;

    mem_port_arbiter_if p_if();

    grant_t grant_q[$];
    resp_t  fe_q[$];
    resp_t  mem_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          model_en = 1'b1;
    int          ack_delay = 1;
    logic [63:0] model_rdata = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.MAX_MEM_BURST(4)) dut (
        .CLK       (clk),
        .RESET     (reset),
        .FE_REQ    (fe_req),
        .FE_ADDR   (fe_addr),
        .FE_FLUSH  (fe_flush),
        .FE_RDATA  (fe_rdata),
        .FE_RVALID (fe_rvalid),
        .FE_STALL  (fe_stall),
        .MEM_REQ   (mem_req),
        .MEM_WE    (mem_we),
        .MEM_SIZE  (mem_size),
        .MEM_ADDR  (mem_addr),
        .MEM_WDATA (mem_wdata),
        .MEM_RDATA (mem_rdata),
        .MEM_RVALID(mem_rvalid),
        .MEM_STALL (mem_stall),
        .P_REQ     (p_if.p_req),
        .P_WE      (p_if.p_we),
        .P_SIZE    (p_if.p_size),
        .P_ADDR    (p_if.p_addr),
        .P_WDATA   (p_if.p_wdata),
        .P_ACK     (p_if.p_ack),
        .P_RDATA   (p_if.p_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_grant(input logic [63:0] addr, input logic we, input logic [1:0] size,
                              input logic [63:0] wdata);
        grant_t g;
        g.addr = addr; g.we = we; g.size = size; g.wdata = wdata;
        grant_q.push_back(g);
    endtask

    task automatic push_fe(input logic [63:0] data, input int at_cyc);
        resp_t r;
        r.data = data; r.cyc = at_cyc;
        fe_q.push_back(r);
    endtask

    task automatic push_mem(input logic [63:0] data, input int at_cyc);
        resp_t r;
        r.data = data; r.cyc = at_cyc;
        mem_q.push_back(r);
    endtask

    // Bounded waits, polled on the falling edge.
    task automatic wait_fe_rvalid(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (fe_rvalid) seen = 1'b1;
        end
        check("fe_rvalid_within_budget", seen, 1'b1);
    endtask

    task automatic wait_mem_rvalid(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (mem_rvalid) seen = 1'b1;
        end
        check("mem_rvalid_within_budget", seen, 1'b1);
    endtask

    task automatic wait_p_req(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (p_if.p_req) seen = 1'b1;
        end
        check("p_req_within_budget", seen, 1'b1);
    endtask

    // Memory model: acknowledge ack_delay cycles after P_REQ rises, for one cycle.
    initial begin
        int cnt;
        cnt = 0;
        p_if.p_ack   = 1'b0;
        p_if.p_rdata = '0;
        forever begin
            @(negedge clk);
            if (model_en) begin
                if (p_if.p_req && !p_if.p_ack) begin
                    cnt++;
                    if (cnt > ack_delay) begin
                        p_if.p_ack   = 1'b1;
                        p_if.p_rdata = model_rdata;
                    end
                end else begin
                    p_if.p_ack = 1'b0;
                    cnt        = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: compare each new port request and each RVALID pulse against the queues.
    initial begin
        grant_t g;
        resp_t  r;
        logic   prev_req;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (p_if.p_req && !prev_req) begin
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", grant_q.size(), 1);
                end else begin
                    g = grant_q.pop_front();
                    check("grant_addr", p_if.p_addr, g.addr);
                    check("grant_we", p_if.p_we, g.we);
                    check("grant_size", p_if.p_size, g.size);
                    check("grant_wdata", p_if.p_wdata, g.wdata);
                end
            end
            prev_req = p_if.p_req;
            if (fe_rvalid) begin
                if (fe_q.size() == 0) begin
                    check("unexpected_fe_rvalid", fe_q.size(), 1);
                end else begin
                    r = fe_q.pop_front();
                    check("fe_rdata", fe_rdata, r.data);
                    if (r.cyc >= 0) check("fe_rvalid_cycle", cyc, r.cyc);
                end
            end
            if (mem_rvalid) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_rvalid", mem_q.size(), 1);
                end else begin
                    r = mem_q.pop_front();
                    check("mem_rdata", mem_rdata, r.data);
                    if (r.cyc >= 0) check("mem_rvalid_cycle", cyc, r.cyc);
                end
            end
        end
    end

    // Watchdog: the run is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        int p;
        int hold;
        reset = 1'b1;
        fe_req = 1'b0; fe_flush = 1'b0; fe_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_p_req", p_if.p_req, 1'b0);
        check("rst_p_we", p_if.p_we, 1'b0);
        check("rst_p_size", p_if.p_size, 2'd0);
        check("rst_p_addr", p_if.p_addr, 64'h0);
        check("rst_p_wdata", p_if.p_wdata, 64'h0);
        check("rst_fe_rvalid", fe_rvalid, 1'b0);
        check("rst_mem_rvalid", mem_rvalid, 1'b0);
        check("rst_fe_rdata", fe_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 64'h0);
        check("rst_state", dut.state_q, IDLE);
        reset = 1'b0;
        @(negedge clk);

        // Lone fetch at 0x1004: upper word, RVALID three cycles after the request.
        model_rdata = 64'hAAAAAAAA_BBBBBBBB;
        ack_delay   = 1;
        push_grant(64'h1004, 1'b0, 2'd2, 64'h0);
        push_fe(64'hAAAAAAAA, cyc + 3);
        fe_addr = 64'h1004;
        fe_req  = 1'b1;
        wait_fe_rvalid(20);
        fe_req = 1'b0;
        @(negedge clk);

        // Flush in IDLE blocks FE but MEM is still granted.
        model_rdata = 64'h01234567_89ABCDEF;
        push_grant(64'h2200, 1'b0, 2'd3, 64'h0);
        push_mem(64'h01234567_89ABCDEF, -1);
        fe_addr = 64'h1100; fe_req = 1'b1; fe_flush = 1'b1;
        mem_addr = 64'h2200; mem_we = 1'b0; mem_size = 2'd3; mem_wdata = '0; mem_req = 1'b1;
        wait_mem_rvalid(20);
        fe_req = 1'b0; fe_flush = 1'b0; mem_req = 1'b0;
        @(negedge clk);

        // Both requesters saturated: M,M,M,M,F,M,M,M,M,F.
        model_rdata = 64'h55556666_77778888;
        fe_addr  = 64'h1010;
        mem_addr = 64'h2000; mem_we = 1'b0; mem_size = 2'd3; mem_wdata = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                push_grant(64'h1010, 1'b0, 2'd2, 64'h0);
                push_fe(64'h77778888, -1);
            end else begin
                push_grant(64'h2000, 1'b0, 2'd3, 64'h0);
                push_mem(64'h55556666_77778888, -1);
            end
        end
        fe_req = 1'b1; mem_req = 1'b1;
        wait_fe_rvalid(40);
        wait_fe_rvalid(40);
        fe_req = 1'b0; mem_req = 1'b0;
        @(negedge clk);

        // Doubleword store: write data on the port, MEM_RDATA forced to zero.
        model_rdata = 64'hDEADBEEF_CAFEF00D;
        push_grant(64'h3000, 1'b1, 2'd3, 64'h11223344_55667788);
        push_mem(64'h0, -1);
        mem_addr = 64'h3000; mem_we = 1'b1; mem_size = 2'd3; mem_wdata = 64'h11223344_55667788;
        mem_req  = 1'b1;
        wait_mem_rvalid(20);
        mem_req = 1'b0; mem_we = 1'b0; mem_wdata = '0;
        @(negedge clk);

        // Flush in FE_WAIT: squashed fetch silent, redirected fetch at 0x4000 returns.
        model_rdata = 64'h0BADF00D_12345678;
        ack_delay   = 3;
        push_grant(64'h1008, 1'b0, 2'd2, 64'h0);
        fe_addr = 64'h1008;
        fe_req  = 1'b1;
        wait_p_req(10);
        p = cyc;
        fe_flush = 1'b1; fe_req = 1'b0;
        @(negedge clk);
        fe_flush = 1'b0;
        push_grant(64'h4000, 1'b0, 2'd2, 64'h0);
        push_fe(64'h12345678, p + 9);
        fe_addr = 64'h4000;
        fe_req  = 1'b1;
        wait_fe_rvalid(30);
        fe_req = 1'b0;
        @(negedge clk);

        // Reset in MEM_WAIT, late ack one cycle after reset is ignored.
        model_en = 1'b0;
        push_grant(64'h5000, 1'b0, 2'd2, 64'h0);
        mem_addr = 64'h5000; mem_we = 1'b0; mem_size = 2'd2;
        mem_req  = 1'b1;
        wait_p_req(10);
        reset = 1'b1; mem_req = 1'b0;
        @(negedge clk);
        check("reset_drops_p_req", p_if.p_req, 1'b0);
        check("reset_state_idle", dut.state_q, IDLE);
        check("reset_clears_fe_rdata", fe_rdata, 32'h0);
        reset = 1'b0;
        p_if.p_ack = 1'b1; p_if.p_rdata = 64'h99;
        @(negedge clk);
        p_if.p_ack = 1'b0;
        check("late_ack_no_mem_rvalid", mem_rvalid, 1'b0);
        check("late_ack_no_p_req", p_if.p_req, 1'b0);
        @(negedge clk);
        check("late_ack_state_idle", dut.state_q, IDLE);
        model_en = 1'b1;

        // Ack held off 10 cycles: port request stable, both stages stalled.
        model_rdata = 64'hFEDCBA98_76543210;
        ack_delay   = 10;
        push_grant(64'h6000, 1'b0, 2'd2, 64'h0);
        push_mem(64'hFEDCBA98_76543210, -1);
        push_grant(64'h600C, 1'b0, 2'd2, 64'h0);
        push_fe(64'hFEDCBA98, -1);
        fe_addr = 64'h600C; fe_req = 1'b1;
        mem_addr = 64'h6000; mem_we = 1'b0; mem_size = 2'd2; mem_req = 1'b1;
        wait_p_req(10);
        hold = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_rvalid) break;
            hold++;
            check("hold_p_req", p_if.p_req, 1'b1);
            check("hold_p_addr", p_if.p_addr, 64'h6000);
            check("hold_fe_stall", fe_stall, 1'b1);
            check("hold_mem_stall", mem_stall, 1'b1);
        end
        check("hold_cycles", hold, 10);
        check("mem_stall_released", mem_stall, 1'b0);
        check("fe_stall_still_high", fe_stall, 1'b1);
        mem_req = 1'b0;
        wait_fe_rvalid(40);
        check("fe_stall_released", fe_stall, 1'b0);
        fe_req = 1'b0;
        repeat (3) @(negedge clk);

        check("grant_q_drained", grant_q.size(), 0);
        check("fe_q_drained", fe_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
